// File: rtl/key_sw_conditioner.sv
// Synchronizes and debounces DE1-SoC keys (active-low) and slide switches, and
// derives per-key press/release pulses plus a sticky, software-clearable press capture.
module key_sw_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] key_raw_n,
  input  logic [9:0] sw_raw,
  input  logic [3:0] edge_clear,
  output logic [3:0] key_export,
  output logic [9:0] sw_export,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_edge
);

  localparam int NCH = 14;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   raw_in;
  logic [NCH-1:0]   s1_q;
  logic [NCH-1:0]   s2_q;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [3:0]       press_q;
  logic [3:0]       press_d;
  logic [3:0]       release_q;
  logic [3:0]       release_d;
  logic [3:0]       edge_q;
  logic [3:0]       edge_d;

  // Keys occupy channels 3:0, inverted so every channel reads 1 = active.
  assign raw_in = {sw_raw, ~key_raw_n};

  // Any agreement between s2 and stable restarts the run of differing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press in the same cycle as a clear keeps the capture bit set.
  always_comb begin
    press_d   = stable_d[3:0] & ~stable_q[3:0];
    release_d = ~stable_d[3:0] & stable_q[3:0];
    edge_d    = (edge_q & ~edge_clear) | press_d;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      edge_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= raw_in;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      edge_q    <= edge_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign key_export  = stable_q[3:0];
  assign sw_export   = stable_q[NCH-1:4];
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_edge    = edge_q;

endmodule
